// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester adder arbiter.
package adder_arb_pkg;

    localparam int DATA_W_DEF = 7;
    localparam int SUM_W      = DATA_W_DEF + 1;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/adder_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
// Grant is combinational from req; the pointer moves only when a grant is
// actually taken (advance), so a stalled grant keeps its priority.
//
// last_gnt | meaning
// ---------+---------------------------------------------
// REQ0     | requester 0 served last, requester 1 wins a tie
// REQ1     | requester 1 served last, requester 0 wins a tie (reset)
module rr_arb2
    import adder_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);

    req_id_t last_gnt_q;
    req_id_t last_gnt_d;

    // Grant selection: single requester wins outright, a tie goes to the other one.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_q == REQ1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        gnt_id = gnt[1] ? REQ1 : REQ0;
    end

    // Pointer next state: follow the grant only when it was accepted.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (advance) begin
            last_gnt_d = gnt_id;
        end
    end

    // Pointer register; reset points at requester 1 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_gnt_q <= REQ1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered ADDER between two valid/ready requesters.
// Sums come back on a single response channel tagged with the owner id.
// Response backpressure freezes the ADDER by dropping its enable.
// Optional grant statistics are enabled with ADDER_ARB_STAT_EN.
//
// state            | meaning
// -----------------+------------------------------------------------
// resp_valid_q = 0 | no result pending, ADDER free to take a new pair
// resp_valid_q = 1 | ADDER output is the response of resp_id_q
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef ADDER_ARB_STAT_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W:0]   resp_sum,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] add_in_a,
    output logic [DATA_W-1:0] add_in_b,
    output logic              add_enable,
    input  logic [DATA_W:0]   add_out
`ifdef ADDER_ARB_STAT_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

    logic       stall;
    logic [1:0] gnt;
    req_id_t    gnt_id;
    logic       acc0;
    logic       acc1;
    logic       accept;

    logic       resp_valid_q;
    logic       resp_valid_d;
    req_id_t    resp_id_q;
    req_id_t    resp_id_d;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    // Handshake: ready follows the grant unless the response is stuck or reset is held.
    always_comb begin
        stall      = resp_valid_q & ~resp_ready;
        add_enable = ~stall;
        req0_ready = gnt[0] & ~stall & ~rst_n;
        req1_ready = gnt[1] & ~stall & ~rst_n;
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready;
        accept     = acc0 | acc1;
    end

    // Operand mux toward the ADDER; idle cycles present zeros.
    always_comb begin
        add_in_a = '0;
        add_in_b = '0;
        if (gnt[0]) begin
            add_in_a = req0_a;
            add_in_b = req0_b;
        end else if (gnt[1]) begin
            add_in_a = req1_a;
            add_in_b = req1_b;
        end
    end

    // Response next state: hold everything while stalled, else track acceptance.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        if (!stall) begin
            resp_valid_d = accept;
        end
        if (accept) begin
            resp_id_d = gnt_id;
        end
    end

    // Response registers; reset discards any result still in the ADDER.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= REQ0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

    // The ADDER output is the sum; it is frozen by add_enable during a stall.
    always_comb begin
        resp_valid = resp_valid_q;
        resp_id    = resp_id_q;
        resp_sum   = add_out;
    end

`ifdef ADDER_ARB_STAT_EN
    logic [CNT_W-1:0] gnt_cnt0_q;
    logic [CNT_W-1:0] gnt_cnt0_d;
    logic [CNT_W-1:0] gnt_cnt1_q;
    logic [CNT_W-1:0] gnt_cnt1_d;

    // Saturating per-requester acceptance counters.
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (acc0 && (gnt_cnt0_q != {CNT_W{1'b1}})) begin
            gnt_cnt0_d = gnt_cnt0_q + 1'b1;
        end
        if (acc1 && (gnt_cnt1_q != {CNT_W{1'b1}})) begin
            gnt_cnt1_d = gnt_cnt1_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural ADDER.
// Expected (id, sum) pairs are queued at acceptance and compared at response.
module tb_adder_arbiter;

    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          resp_valid, resp_id, resp_ready;
    logic [DW:0]   resp_sum;
    logic [DW-1:0] add_in_a, add_in_b;
    logic          add_enable;
    logic [DW:0]   add_out;
`ifdef ADDER_ARB_STAT_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
    int            mdl_cnt0 = 0;
    int            mdl_cnt1 = 0;
`endif

    typedef struct {
        logic        id;
        logic [DW:0] sum;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_ready (resp_ready),
        .add_in_a   (add_in_a),
        .add_in_b   (add_in_b),
        .add_enable (add_enable),
        .add_out    (add_out)
`ifdef ADDER_ARB_STAT_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    // Behavioural ADDER: registered sum, holds while enable is low.
    always @(posedge clk) begin
        if (add_enable) begin
            add_out <= {1'b0, add_in_a} + {1'b0, add_in_b};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on response handshake, push on acceptance, flush on reset.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("resp_unexpected_sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("resp_id", resp_id, e.id);
                check("resp_sum", resp_sum, e.sum);
            end
        end
        if (rst_n) begin
            sb.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                e.id  = 1'b0;
                e.sum = {1'b0, req0_a} + {1'b0, req0_b};
                sb.push_back(e);
`ifdef ADDER_ARB_STAT_EN
                mdl_cnt0 = (mdl_cnt0 == 65535) ? mdl_cnt0 : mdl_cnt0 + 1;
`endif
            end
            if (req1_valid && req1_ready) begin
                e.id  = 1'b1;
                e.sum = {1'b0, req1_a} + {1'b0, req1_b};
                sb.push_back(e);
`ifdef ADDER_ARB_STAT_EN
                mdl_cnt1 = (mdl_cnt1 == 65535) ? mdl_cnt1 : mdl_cnt1 + 1;
`endif
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    initial begin
        // Reset with requester 0 pending: nothing may be accepted.
        rst_n = 1'b1;
        resp_ready = 1'b1;
        drive(1'b1, 7'd3, 7'd4, 1'b0, 7'd0, 7'd0);
        for (int i = 0; i < 2; i++) begin
            at_sample();
            check("rst_req0_ready", req0_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
        end

        // Contention right after reset: requester 0 first, then strict alternation.
        next_cycle();
        rst_n = 1'b0;
        drive(1'b1, 7'd5, 7'd6, 1'b1, 7'd127, 7'd127);
        for (int i = 0; i < 4; i++) begin
            at_sample();
            check("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("cont_rdy1", req1_ready, (i % 2 == 0) ? 0 : 1);
            next_cycle();
        end

        // Single pair from requester 0, then idle operands must be zero.
        drive(1'b1, 7'd3, 7'd4, 1'b0, 7'd0, 7'd0);
        at_sample();
        check("single_add_in_a", add_in_a, 3);
        next_cycle();
        drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
        req0_a = 7'd9;
        at_sample();
        check("single_resp_valid", resp_valid, 1);
        check("single_resp_sum", resp_sum, 7);
        check("idle_add_in_a", add_in_a, 0);
        check("idle_add_in_b", add_in_b, 0);
        next_cycle();

        // Backpressure: req1 10+20 held three cycles while req0 waits.
        drive(1'b0, 7'd0, 7'd0, 1'b1, 7'd10, 7'd20);
        next_cycle();
        drive(1'b1, 7'd9, 7'd8, 1'b0, 7'd0, 7'd0);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_sample();
            check("bp_add_enable", add_enable, 0);
            check("bp_resp_sum", resp_sum, 30);
            check("bp_req0_ready", req0_ready, 0);
            next_cycle();
        end
        resp_ready = 1'b1;
        at_sample();
        check("bp_release_req0_ready", req0_ready, 1);
        next_cycle();
        drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
        at_sample();
        check("bp_after_sum", resp_sum, 17);
        next_cycle();

        // Reset mid-flight: 1+1 accepted, reset next cycle, result dropped.
        resp_ready = 1'b0;
        drive(1'b1, 7'd1, 7'd1, 1'b0, 7'd0, 7'd0);
        next_cycle();
        drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
        rst_n = 1'b1;
        next_cycle();
        rst_n = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_sample();
            check("midrst_resp_valid", resp_valid, 0);
            next_cycle();
        end

        // Pointer restored by reset: tie goes to requester 0 again.
        drive(1'b1, 7'd60, 7'd2, 1'b1, 7'd33, 7'd44);
        at_sample();
        check("post_rst_rdy0", req0_ready, 1);
        check("post_rst_rdy1", req1_ready, 0);
        next_cycle();

        // Single requester 1 streaming with random operands.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'd0, 7'd0, 1'b1, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            at_sample();
            check("stream_rdy1", req1_ready, 1);
            next_cycle();
        end
        drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
        repeat (3) next_cycle();
        at_sample();
        check("sb_drained", sb.size(), 0);
`ifdef ADDER_ARB_STAT_EN
        check("gnt_cnt0", gnt_cnt0, mdl_cnt0);
        check("gnt_cnt1", gnt_cnt1, mdl_cnt1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
